// File: rtl/reg_bus_arbiter.sv
// Two-port round-robin arbiter that serialises accesses to the 16-bit configuration
// register list. It drives the ce/we strobes and returns read data after RD_LAT cycles.
module reg_bus_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        reg_ce,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic        last_gnt, last_gnt_d;
    logic        sel;
    logic        gnt_d, we_d, ce_d, ack0_d, ack1_d, busy_d;
    logic [7:0]  addr_d;
    logic [15:0] wdata_d, rdata0_d, rdata1_d;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= 1'b1;
            gnt_id    <= 1'b0;
            reg_we    <= 1'b0;
            reg_ce    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            last_gnt  <= last_gnt_d;
            gnt_id    <= gnt_d;
            reg_we    <= we_d;
            reg_ce    <= ce_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
            busy      <= busy_d;
        end
    end

    // Every output is computed here one cycle ahead so that it is registered.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        last_gnt_d = last_gnt;
        gnt_d      = gnt_id;
        we_d       = reg_we;
        addr_d     = reg_addr;
        wdata_d    = reg_wdata;
        rdata0_d   = rdata0;
        rdata1_d   = rdata1;
        ce_d       = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        sel        = (req0 && req1) ? ~last_gnt : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d      = sel;
                    last_gnt_d = sel;
                    we_d       = sel ? we1 : we0;
                    addr_d     = sel ? addr1 : addr0;
                    wdata_d    = sel ? wdata1 : wdata0;
                    ce_d       = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (reg_we) begin
                    ack0_d  = ~gnt_id;
                    ack1_d  = gnt_id;
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    if (gnt_id) rdata1_d = reg_rdata;
                    else        rdata0_d = reg_rdata;
                    ack0_d  = ~gnt_id;
                    ack1_d  = gnt_id;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with RD_LAT = 3 and a latency-accurate register model
// that shows junk on reg_rdata except in the one cycle the arbiter should sample it.
module tb_reg_bus_arbiter;

    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, reg_ce, reg_we, busy, gnt_id;
    logic [15:0] rdata0, rdata1, reg_wdata, reg_rdata;
    logic [7:0]  reg_addr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    logic [2:0] sr;

    reg_bus_arbiter #(.RD_LAT(LAT)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 CLK = ~CLK;

    // Register model: data is valid only in the cycle LAT cycles after reg_ce.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[1:0], reg_ce};
    end
    assign reg_rdata = !sr[LAT-1] ? 16'hDEAD :
                       (reg_addr == 8'h40) ? 16'hBEEF : {reg_addr, ~reg_addr};

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (reg_ce) ce_cnt   <= ce_cnt + 1;
        if (ack0)   ack0_cnt <= ack0_cnt + 1;
        if (ack1)   ack1_cnt <= ack1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int base_ce, base_a0, last_ce_cyc;
    logic [7:0] a_exp;

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ce", reg_ce, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_rdata0", rdata0, 0);
        rst_n = 1'b1;
        tick();

        // Single write from port 0
        req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 16'hA55A;
        tick();
        chk("wr_ce", reg_ce, 1);
        chk("wr_we", reg_we, 1);
        chk("wr_addr", reg_addr, 8'h12);
        chk("wr_wdata", reg_wdata, 16'hA55A);
        chk("wr_busy", busy, 1);
        chk("wr_gnt", gnt_id, 0);
        chk("wr_ack0_early", ack0, 0);
        tick();
        chk("wr_ack0", ack0, 1);
        chk("wr_ack1", ack1, 0);
        chk("wr_ce_off", reg_ce, 0);
        req0 = 0;
        tick();
        chk("wr_ack0_1cyc", ack0, 0);
        chk("wr_idle", busy, 0);
        chk("wr_wdata_hold", reg_wdata, 16'hA55A);
        chk("wr_no_ack1", ack1_cnt, 0);

        // Read from port 1, RD_LAT = 3
        req1 = 1; we1 = 0; addr1 = 8'h40;
        tick();
        chk("rd_ce", reg_ce, 1);
        chk("rd_we", reg_we, 0);
        chk("rd_gnt", gnt_id, 1);
        req1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_ack1_wait", ack1, 0);
            chk("rd_busy_wait", busy, 1);
        end
        tick();
        chk("rd_ack1", ack1, 1);
        chk("rd_rdata1", rdata1, 16'hBEEF);
        chk("rd_rdata0", rdata0, 0);
        tick();
        chk("rd_ack1_1cyc", ack1, 0);
        chk("rd_rdata1_hold", rdata1, 16'hBEEF);
        chk("rd_idle", busy, 0);

        // Contention: both ports write continuously
        req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 16'h2222;
        last_ce_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            a_exp = (i % 2 == 0) ? 8'h10 : 8'h20;
            chk("ct_ce", reg_ce, 1);
            chk("ct_gnt", gnt_id, (i % 2));
            chk("ct_addr", reg_addr, a_exp);
            if (i > 0) chk("ct_spacing", cyc - last_ce_cyc, 3);
            last_ce_cyc = cyc;
            tick();
            chk("ct_ack0", ack0, (i % 2 == 0));
            chk("ct_ack1", ack1, (i % 2 == 1));
            tick();
            chk("ct_ack0_1cyc", ack0, 0);
            chk("ct_ack1_1cyc", ack1, 0);
            if (i == 3) begin
                req0 = 0; req1 = 0;
            end
        end
        tick();
        chk("ct_stop", busy, 0);

        // Port 0 read with its request dropped during WAIT
        base_ce = ce_cnt;
        req0 = 1; we0 = 0; addr0 = 8'h21;
        tick();
        chk("dr_ce", reg_ce, 1);
        tick();
        req0 = 0;
        tick(); tick();
        chk("dr_ack0_wait", ack0, 0);
        tick();
        chk("dr_ack0", ack0, 1);
        chk("dr_rdata0", rdata0, 16'h21DE);
        tick();
        chk("dr_one_ce", ce_cnt - base_ce, 1);

        // Reset during WAIT of a port 1 read
        req1 = 1; we1 = 0; addr1 = 8'h40;
        tick(); tick();
        chk("rs_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_ce", reg_ce, 0);
        chk("rs_ack1", ack1, 0);
        chk("rs_rdata1", rdata1, 0);
        tick(); tick();
        chk("rs_ack1_hold", ack1, 0);
        rst_n = 1'b1;
        tick();
        chk("rs_regrant_gnt", gnt_id, 1);
        chk("rs_regrant_ce", reg_ce, 1);
        req1 = 0;
        tick(); tick(); tick();
        chk("rs_ack1_wait", ack1, 0);
        tick();
        chk("rs_ack1", ack1, 1);
        chk("rs_rdata1_new", rdata1, 16'hBEEF);
        tick();

        // Reset restores last_gnt = 1: port 0 last won, yet port 0 wins again after reset
        req0 = 1; we0 = 1; addr0 = 8'h33; wdata0 = 16'h3333;
        tick();
        chk("lg_gnt0", gnt_id, 0);
        rst_n = 1'b0;
        #1;
        chk("lg_ce_drop", reg_ce, 0);
        req1 = 1; we1 = 1; addr1 = 8'h44;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("lg_gnt_after_rst", gnt_id, 0);
        chk("lg_addr_after_rst", reg_addr, 8'h33);
        req0 = 0; req1 = 0;
        tick();
        chk("lg_ack0", ack0, 1);
        tick();

        // Held request yields two separate transactions with an IDLE cycle between them
        base_ce = ce_cnt; base_a0 = ack0_cnt;
        req0 = 1; we0 = 1; addr0 = 8'h55; wdata0 = 16'h5555;
        tick();
        chk("hd_ce1", reg_ce, 1);
        tick();
        chk("hd_ack1st", ack0, 1);
        tick();
        chk("hd_idle_busy", busy, 0);
        chk("hd_idle_ce", reg_ce, 0);
        tick();
        chk("hd_ce2", reg_ce, 1);
        tick();
        chk("hd_ack2nd", ack0, 1);
        req0 = 0;
        tick(); tick();
        chk("hd_end_busy", busy, 0);
        chk("hd_ce_count", ce_cnt - base_ce, 2);
        chk("hd_ack_count", ack0_cnt - base_a0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-port round-robin arbiter that lets two requesters share the single 16-bit configuration register list. Port 0 is the host path: the selected I2C/SPI slave traffic, widened to 16 bits. Port 1 is an on-chip requester, such as a test sequencer or power-up loader. The block sits between those requesters and the register list, serialises their accesses, and drives the register list's chip-enable/write-enable strobes. It also returns read data, with a fixed, parameterised read latency.

## Interface
Parameters:
- RD_LAT, 1: cycles from the reg_ce cycle to valid reg_rdata; legal range 1..7.

Ports:
- CLK  in  1  process clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request, held high until ack
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  8  register address
- wdata0 / wdata1  in  16  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  16  read data; valid during ack, held until that port's next read ack
- reg_ce  out  1  register chip enable, one-cycle pulse
- reg_we  out  1  register write enable, qualifies reg_ce
- reg_addr  out  8  register address
- reg_wdata  out  16  register write data
- reg_rdata  in  16  register read data
- busy  out  1  high in any state other than IDLE
- gnt_id  out  1  port owning the current or last transaction

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not equal to last_gnt.
  - On a grant:
    - latch we, addr and wdata of the winner into reg_we, reg_addr, reg_wdata;
    - set gnt_id and last_gnt;
    - go to ISSUE.
- **ISSUE**
  - reg_ce = 1 for exactly this cycle.
  - For a write, go to DONE.
  - For a read, load wait counter = RD_LAT and go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - In the cycle where the counter is 1, capture reg_rdata into rdata of the granted port at the closing edge, then go to DONE.
- **DONE**
  - ack of the granted port = 1 for exactly this cycle.
  - Go to IDLE. req inputs are ignored in DONE.
- **Requester rule:** a requester must drop req in the cycle after its ack. If req is still high in IDLE, it is a new request.
- **Request dropped mid-transaction:** if the granted req falls before ack, the transaction still completes and ack still pulses. The register access is never cancelled.
- **Write data:** reg_wdata and reg_addr keep their latched values after ISSUE and change only on the next grant.
- **Fairness:** last_gnt resets to 1, so port 0 wins the first contested cycle. With continuous contention, grants alternate 0,1,0,1.
- **Reset values:**
  - all outputs 0;
  - state = IDLE;
  - wait counter 0;
  - last_gnt 1.

## Timing
- Let G be the IDLE cycle in which req is sampled high and a grant is made.
- ISSUE (reg_ce = 1) is cycle G+1.
- **Write:** DONE/ack at G+2. Spacing between back-to-back writes is 3 cycles (IDLE, ISSUE, DONE).
- **Read:**
  - WAIT spans G+2 .. G+1+RD_LAT;
  - reg_rdata is sampled at the end of cycle G+1+RD_LAT;
  - ack and rdata are valid at G+2+RD_LAT.
- **Minimum request-to-ack latency:**
  - write: 2 cycles after G;
  - read: RD_LAT+2 cycles after G.
- **Reset mid-transaction:** asynchronous return to IDLE. reg_ce and ack drop immediately and the access is lost. No partial ack is ever issued after reset.
- **Simultaneous events:**
  - a req that rises during ISSUE/WAIT/DONE is served only from the next IDLE;
  - the other port's req is never lost, only deferred.

## Test plan
- **Single write:** req0 = 1, we0 = 1, addr0 = 8'h12, wdata0 = 16'hA55A.
  - Required: reg_ce = 1, reg_we = 1 and reg_addr = 8'h12, reg_wdata = 16'hA55A at G+1; ack0 at G+2; ack1 never.
- **Read with RD_LAT = 3:** req1 = 1, we1 = 0, addr1 = 8'h40; a register model returns 16'hBEEF 3 cycles after reg_ce.
  - Required: ack1 and rdata1 = 16'hBEEF at G+5; rdata0 unchanged.
- **Contention:** req0 and req1 both held through 4 write transactions.
  - Required: grant order 0,1,0,1; gnt_id matches; each ack is exactly 1 cycle; reg_ce pulses spaced 3 cycles apart.
- **Drop request mid-read:** req0 read, then req0 deasserted during WAIT.
  - Required: ack0 still pulses at G+2+RD_LAT; exactly one reg_ce.
- **Reset during WAIT:** rst_n low for 2 cycles.
  - Required: busy = 0, ack = 0, reg_ce = 0 immediately. After release with req1 = 1 still high, the next grant goes to port 0 if req0 is also high, otherwise to port 1 (last_gnt reset to 1).
- **Held request:** req0 kept high after ack0 for 2 transactions.
  - Required: 2 separate reg_ce pulses and 2 acks; IDLE cycle present between them.
